// File: rtl/video_pattern_gen.sv
// Raster timing generator and test-pattern source: counts h/v position, derives
// hs/vs/de and produces color bars, gray ramp, checkerboard or a solid color.
module video_pattern_gen #(
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int CHK_SHIFT = 6
) (
  input  logic        pclk_i,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] solid_i,
  output logic [23:0] rgb_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] BW_LAST = 12'(BAR_W - 1);

  logic [11:0] h_q, h_d, v_q, v_d, bcnt_q, bcnt_d;
  logic [2:0]  bar_q, bar_d;
  logic        run_q, run_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] sol_q, sol_d;

  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [11:0] x_q, x_d, y_q, y_d;

  logic        live, de, sof;
  logic [23:0] pix, bar_rgb;

  always_comb begin
    // run_q marks that the counter state is a real raster position; the first
    // cycle after enable only arms it, so (0,0) is the first counted position.
    live = en_i && run_q;
    de   = live && (h_q < H_ACT) && (v_q < V_ACT);
    sof  = live && (h_q == '0) && (v_q == '0);

    pat_d = sof ? pattern_i : pat_q;
    sol_d = sof ? solid_i : sol_q;

    case (bar_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

    case (pat_d)
      2'd0:    pix = bar_rgb;
      2'd1:    pix = {h_q[7:0], h_q[7:0], h_q[7:0]};
      2'd2:    pix = (h_q[CHK_SHIFT] ^ v_q[CHK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      default: pix = sol_d;
    endcase

    rgb_d = de ? pix : 24'h000000;
    de_d  = de;
    hs_d  = (live && h_q >= HS_BEG && h_q <= HS_END) ? HS_POL : ~HS_POL;
    vs_d  = (live && v_q >= VS_BEG && v_q <= VS_END) ? VS_POL : ~VS_POL;
    x_d   = de ? h_q : '0;
    y_d   = de ? v_q : '0;
    fs_d  = de && sof;

    h_d    = h_q;
    v_d    = v_q;
    bar_d  = bar_q;
    bcnt_d = bcnt_q;
    run_d  = run_q;
    if (!en_i) begin
      h_d    = '0;
      v_d    = '0;
      bar_d  = '0;
      bcnt_d = '0;
      run_d  = 1'b0;
    end else if (!run_q) begin
      run_d = 1'b1;
    end else if (h_q == H_LAST) begin
      h_d    = '0;
      v_d    = (v_q == V_LAST) ? '0 : v_q + 12'd1;
      bar_d  = '0;
      bcnt_d = '0;
    end else begin
      h_d = h_q + 12'd1;
      // Bar index tracks h_cnt / BAR_W incrementally, saturating at the last bar.
      if (h_q < H_ACT) begin
        if (bcnt_q == BW_LAST) begin
          bcnt_d = '0;
          if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk_i or posedge rst) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      bar_q  <= '0;
      bcnt_q <= '0;
      run_q  <= 1'b0;
      pat_q  <= '0;
      sol_q  <= '0;
      rgb_q  <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      bar_q  <= bar_d;
      bcnt_q <= bcnt_d;
      run_q  <= run_d;
      pat_q  <= pat_d;
      sol_q  <= sol_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 24x8 raster with active-low hsync.
module tb_video_pattern_gen;
  logic        pclk_i = 1'b0;
  logic        rst;
  logic        en_i;
  logic [1:0]  pattern_i;
  logic [23:0] solid_i;
  logic [23:0] rgb_o;
  logic        hs_o, vs_o, de_o, frame_start_o;
  logic [11:0] x_o, y_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .CHK_SHIFT(1)
  ) dut (
    .pclk_i(pclk_i), .rst(rst), .en_i(en_i), .pattern_i(pattern_i),
    .solid_i(solid_i), .rgb_o(rgb_o), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
    .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk_i);
      @(negedge pclk_i);
    end
  endtask

  // Called on the sample where frame_start_o should be high; walks one full
  // frame, checking {de,hs,vs,fs}, rgb and {x,y}, then checks the next pulse.
  task automatic run_frame(input int pat, input logic [23:0] sol, input logic [1:0] nxt);
    for (int c = 0; c < 192; c++) begin
      int h, v;
      logic e_de, e_hs, e_vs, e_fs;
      logic [23:0] e_rgb;
      h = c % 24;
      v = c / 24;
      e_de = (h < 16) && (v < 4);
      e_hs = !(h == 18 || h == 19);
      e_vs = (v == 5);
      e_fs = (c == 0);
      e_rgb = 24'h0;
      if (e_de) begin
        case (pat)
          0: e_rgb = bar_col[h / 2];
          1: e_rgb = {3{8'(h)}};
          2: e_rgb = (((h >> 1) ^ (v >> 1)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
          default: e_rgb = sol;
        endcase
      end
      chk("ctl", {28'h0, de_o, hs_o, vs_o, frame_start_o}, {28'h0, e_de, e_hs, e_vs, e_fs});
      chk("rgb", {8'h0, rgb_o}, {8'h0, e_rgb});
      chk("xy", {8'h0, x_o, y_o}, {8'h0, e_de ? 12'(h) : 12'h0, e_de ? 12'(v) : 12'h0});
      if (c == 100) pattern_i = nxt;
      step(1);
    end
    chk("fs_period", {31'h0, frame_start_o}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    en_i = 1'b1;
    pattern_i = 2'd3;
    solid_i = 24'h123456;
    step(3);
    chk("rst_ctl", {28'h0, de_o, hs_o, vs_o, frame_start_o}, 32'b0100);
    chk("rst_rgb", {8'h0, rgb_o}, 32'h0);
    chk("rst_xy", {8'h0, x_o, y_o}, 32'h0);

    rst = 1'b0;
    step(1);
    chk("rel_1", {28'h0, de_o, hs_o, vs_o, frame_start_o}, 32'b0100);
    step(1);
    run_frame(3, 24'h123456, 2'd0);
    run_frame(0, 24'h123456, 2'd2);
    run_frame(2, 24'h123456, 2'd1);
    run_frame(1, 24'h123456, 2'd0);   // pattern_i goes to bars mid-frame
    run_frame(0, 24'h123456, 2'd0);

    step(5);
    chk("pre_drop_de", {31'h0, de_o}, 32'h1);
    en_i = 1'b0;
    step(1);
    chk("drop_ctl", {28'h0, de_o, hs_o, vs_o, frame_start_o}, 32'b0100);
    chk("drop_rgb", {8'h0, rgb_o}, 32'h0);
    step(4);
    en_i = 1'b1;
    step(1);
    chk("en_rise1", {28'h0, de_o, hs_o, vs_o, frame_start_o}, 32'b0100);
    step(1);
    run_frame(0, 24'h123456, 2'd0);

    rst = 1'b1;
    #1;
    chk("async_rst_ctl", {28'h0, de_o, hs_o, vs_o, frame_start_o}, 32'b0100);
    chk("async_rst_rgb", {8'h0, rgb_o}, 32'h0);
    chk("async_rst_xy", {8'h0, x_o, y_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
